// File: rtl/csr_pkg.sv
// Shared CSR definitions for the trap-return path: privilege encodings,
// the xRET FSM state type, default XLEN and the MPP legalisation helper.
package csr_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [1:0] PRIV_U    = 2'd0;
  localparam logic [1:0] PRIV_S    = 2'd1;
  localparam logic [1:0] PRIV_RSVD = 2'd2;
  localparam logic [1:0] PRIV_M    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } xret_state_e;

  // MPP may hold the reserved encoding; returning through it lands in U-mode.
  function automatic logic [1:0] mpp_to_priv(input logic [1:0] mpp);
    logic [1:0] p;
    if (mpp == PRIV_RSVD) begin
      p = PRIV_U;
    end else begin
      p = mpp;
    end
    return p;
  endfunction

endpackage

// File: rtl/xret_pc_unit_if.sv
// Bundle of every non-clock signal of the trap-return unit. The slave
// modport is the unit itself; master is the pipeline/CSR/fetch side.
interface xret_pc_unit_if
  import csr_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            ret_valid;
  logic            ret_is_mret;
  logic            ret_ready;
  logic [1:0]      priv;
  logic            tsr;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] sepc;
  logic [1:0]      mpp;
  logic            spp;
  logic            illegal;
  logic            flush_req;
  logic            flush_ack;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            redir_ready;
  logic            priv_we;
  logic [1:0]      new_priv;
  logic            done_m;
  logic            done_s;

  modport master (
    output ret_valid, ret_is_mret, priv, tsr, mepc, sepc, mpp, spp,
           flush_ack, redir_ready,
    input  ret_ready, illegal, flush_req, redir_valid, redir_pc,
           priv_we, new_priv, done_m, done_s
  );

  modport slave (
    input  ret_valid, ret_is_mret, priv, tsr, mepc, sepc, mpp, spp,
           flush_ack, redir_ready,
    output ret_ready, illegal, flush_req, redir_valid, redir_pc,
           priv_we, new_priv, done_m, done_s
  );

endinterface

// File: rtl/xret_legal_chk.sv
// Privilege legality of an xRET: MRET needs M-mode; SRET is refused from
// U-mode and from S-mode while mstatus.TSR traps it.
module xret_legal_chk
  import csr_pkg::*;
(
  input  logic       ret_is_mret,
  input  logic [1:0] priv,
  input  logic       tsr,
  output logic       legal
);

  logic legal_s;

  // Pure decode of instruction kind against current privilege.
  always_comb begin
    legal_s = 1'b0;
    if (ret_is_mret) begin
      legal_s = (priv == PRIV_M);
    end else if (priv == PRIV_U) begin
      legal_s = 1'b0;
    end else if ((priv == PRIV_S) && tsr) begin
      legal_s = 1'b0;
    end else begin
      legal_s = 1'b1;
    end
  end

  assign legal = legal_s;

endmodule

// File: rtl/xret_pc_unit.sv
// Trap-return redirect unit: accepts MRET/SRET, flushes the pipeline,
// redirects fetch to the frozen xEPC and then tells the CSR block to
// switch privilege and pop the matching mstatus interrupt stack.
module xret_pc_unit
  import csr_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int IALIGN16 = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  xret_pc_unit_if.slave  bus
);

  // With compressed instructions only bit 0 is forced low, otherwise [1:0].
  localparam logic [1:0]      LOW_MASK = (IALIGN16 != 0) ? 2'b10 : 2'b00;
  localparam logic [XLEN-1:0] PC_MASK  = {{(XLEN-2){1'b1}}, LOW_MASK};

  xret_state_e     state_r;
  xret_state_e     state_s;

  logic            legal_s;
  logic            accept_s;
  logic            reject_s;
  logic            enter_redir_s;
  logic            handshake_s;
  logic [XLEN-1:0] tgt_pc_s;
  logic [1:0]      tgt_priv_s;

  logic [XLEN-1:0] pc_r;
  logic [1:0]      tgt_priv_r;
  logic            kind_m_r;

  logic            ret_ready_r;
  logic            illegal_r;
  logic            flush_req_r;
  logic            redir_valid_r;
  logic [XLEN-1:0] redir_pc_r;
  logic            priv_we_r;
  logic [1:0]      new_priv_r;
  logic            done_m_r;
  logic            done_s_r;

  xret_legal_chk u_legal (
    .ret_is_mret (bus.ret_is_mret),
    .priv        (bus.priv),
    .tsr         (bus.tsr),
    .legal       (legal_s)
  );

  // Return target computed from the live CSR values; only sampled on accept.
  always_comb begin
    tgt_pc_s   = {XLEN{1'b0}};
    tgt_priv_s = PRIV_U;
    if (bus.ret_is_mret) begin
      tgt_pc_s   = bus.mepc & PC_MASK;
      tgt_priv_s = mpp_to_priv(bus.mpp);
    end else begin
      tgt_pc_s   = bus.sepc & PC_MASK;
      tgt_priv_s = {1'b0, bus.spp};
    end
  end

  // Next-state and single-cycle event decode.
  always_comb begin
    state_s       = state_r;
    accept_s      = 1'b0;
    reject_s      = 1'b0;
    enter_redir_s = 1'b0;
    handshake_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.ret_valid && legal_s) begin
          accept_s = 1'b1;
          state_s  = ST_FLUSH;
        end else if (bus.ret_valid) begin
          reject_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (bus.flush_ack) begin
          enter_redir_s = 1'b1;
          state_s       = ST_REDIR;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_REDIR: begin
        if (bus.redir_ready) begin
          handshake_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_REDIR;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Freeze target PC, privilege and return kind at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= {XLEN{1'b0}};
      tgt_priv_r <= PRIV_U;
      kind_m_r   <= 1'b0;
    end else if (accept_s) begin
      pc_r       <= tgt_pc_s;
      tgt_priv_r <= tgt_priv_s;
      kind_m_r   <= bus.ret_is_mret;
    end
  end

  // Output registers; levels follow the next state, pulses follow events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_ready_r   <= 1'b1;
      illegal_r     <= 1'b0;
      flush_req_r   <= 1'b0;
      redir_valid_r <= 1'b0;
      redir_pc_r    <= {XLEN{1'b0}};
      priv_we_r     <= 1'b0;
      new_priv_r    <= PRIV_U;
      done_m_r      <= 1'b0;
      done_s_r      <= 1'b0;
    end else begin
      ret_ready_r   <= (state_s == ST_IDLE);
      illegal_r     <= reject_s;
      flush_req_r   <= (state_s == ST_FLUSH);
      redir_valid_r <= (state_s == ST_REDIR);
      priv_we_r     <= handshake_s;
      done_m_r      <= handshake_s & kind_m_r;
      done_s_r      <= handshake_s & ~kind_m_r;
      if (enter_redir_s) begin
        redir_pc_r <= pc_r;
      end
      if (handshake_s) begin
        new_priv_r <= tgt_priv_r;
      end
    end
  end

  assign bus.ret_ready   = ret_ready_r;
  assign bus.illegal     = illegal_r;
  assign bus.flush_req   = flush_req_r;
  assign bus.redir_valid = redir_valid_r;
  assign bus.redir_pc    = redir_pc_r;
  assign bus.priv_we     = priv_we_r;
  assign bus.new_priv    = new_priv_r;
  assign bus.done_m      = done_m_r;
  assign bus.done_s      = done_s_r;

endmodule

// File: tb/tb_xret_pc_unit.sv
// Scoreboard bench for xret_pc_unit. Two instances (4-byte and 2-byte PC
// alignment) share one stimulus stream; each has its own expectation queue
// drained by a negedge monitor.
module tb_xret_pc_unit;

  localparam int EV_ILL   = 0;
  localparam int EV_REDIR = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int          kind;
    logic [63:0] pc;
    logic [1:0]  prv;
    logic        m;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];

  xret_pc_unit_if #(.XLEN(64)) b0 ();
  xret_pc_unit_if #(.XLEN(64)) b1 ();

  assign b1.ret_valid   = b0.ret_valid;
  assign b1.ret_is_mret = b0.ret_is_mret;
  assign b1.priv        = b0.priv;
  assign b1.tsr         = b0.tsr;
  assign b1.mepc        = b0.mepc;
  assign b1.sepc        = b0.sepc;
  assign b1.mpp         = b0.mpp;
  assign b1.spp         = b0.spp;
  assign b1.flush_ack   = b0.flush_ack;
  assign b1.redir_ready = b0.redir_ready;

  xret_pc_unit #(.XLEN(64), .IALIGN16(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  xret_pc_unit #(.XLEN(64), .IALIGN16(1)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input int which, input int kind, input logic [63:0] pc,
                           input logic [1:0] prv, input logic dm, input logic ds,
                           input logic pwe);
    exp_t e;
    int   depth;
    depth = (which == 0) ? q0.size() : q1.size();
    if (depth == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event dut%0d: got kind %0d expected none at %0t",
               which, kind, $time);
    end else begin
      if (which == 0) e = q0.pop_front();
      else            e = q1.pop_front();
      chk($sformatf("ev_kind_dut%0d", which), 64'(kind), 64'(e.kind));
      if (e.kind == EV_REDIR && kind == EV_REDIR) begin
        chk($sformatf("redir_pc_dut%0d", which), pc, e.pc);
      end else if (e.kind == EV_DONE && kind == EV_DONE) begin
        chk($sformatf("new_priv_dut%0d", which), 64'(prv), 64'(e.prv));
        chk($sformatf("done_m_dut%0d", which), 64'(dm), 64'(e.m));
        chk($sformatf("done_s_dut%0d", which), 64'(ds), 64'(!e.m));
        chk($sformatf("priv_we_dut%0d", which), 64'(pwe), 64'd1);
      end
    end
  endtask

  // Monitor for the 4-byte aligned instance.
  always @(negedge clk) begin
    if (b0.illegal) pop_check(0, EV_ILL, 64'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    if (b0.redir_valid && b0.redir_ready)
      pop_check(0, EV_REDIR, b0.redir_pc, 2'd0, 1'b0, 1'b0, 1'b0);
    if (b0.priv_we || b0.done_m || b0.done_s)
      pop_check(0, EV_DONE, 64'd0, b0.new_priv, b0.done_m, b0.done_s, b0.priv_we);
  end

  // Monitor for the 2-byte aligned instance.
  always @(negedge clk) begin
    if (b1.illegal) pop_check(1, EV_ILL, 64'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    if (b1.redir_valid && b1.redir_ready)
      pop_check(1, EV_REDIR, b1.redir_pc, 2'd0, 1'b0, 1'b0, 1'b0);
    if (b1.priv_we || b1.done_m || b1.done_s)
      pop_check(1, EV_DONE, 64'd0, b1.new_priv, b1.done_m, b1.done_s, b1.priv_we);
  end

  task automatic push_ok(input logic [63:0] pc0, input logic [63:0] pc1,
                         input logic [1:0] prv, input logic m);
    q0.push_back('{EV_REDIR, pc0, 2'd0, 1'b0});
    q0.push_back('{EV_DONE, 64'd0, prv, m});
    q1.push_back('{EV_REDIR, pc1, 2'd0, 1'b0});
    q1.push_back('{EV_DONE, 64'd0, prv, m});
  endtask

  task automatic push_ill(input int n);
    for (int i = 0; i < n; i++) begin
      q0.push_back('{EV_ILL, 64'd0, 2'd0, 1'b0});
      q1.push_back('{EV_ILL, 64'd0, 2'd0, 1'b0});
    end
  endtask

  // Legal return: acceptance, ack after ack_dly idle FLUSH cycles, handshake
  // after rdy_dly stalled REDIR cycles.
  task automatic run_ret(input logic m, input logic [1:0] p, input logic t,
                         input int ack_dly, input int rdy_dly, input logic ack_early,
                         input logic corrupt, input logic [63:0] pc0);
    b0.ret_is_mret = m;
    b0.priv        = p;
    b0.tsr         = t;
    b0.ret_valid   = 1'b1;
    b0.flush_ack   = ack_early;
    @(posedge clk); #1;
    b0.ret_valid = 1'b0;
    b0.flush_ack = 1'b0;
    chk("accept_flush_req", 64'(b0.flush_req), 64'd1);
    chk("accept_ret_ready", 64'(b0.ret_ready), 64'd0);
    if (corrupt) begin
      b0.mepc = 64'hDEAD_0000;
      b0.sepc = 64'hDEAD_0000;
      b0.mpp  = 2'd0;
      b0.spp  = 1'b0;
    end
    repeat (ack_dly) begin
      @(posedge clk); #1;
      chk("flush_hold_valid", 64'(b0.redir_valid), 64'd0);
      chk("flush_hold_req", 64'(b0.flush_req), 64'd1);
    end
    b0.flush_ack = 1'b1;
    @(posedge clk); #1;
    b0.flush_ack = 1'b0;
    chk("redir_valid_up", 64'(b0.redir_valid), 64'd1);
    chk("flush_req_down", 64'(b0.flush_req), 64'd0);
    repeat (rdy_dly) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(b0.redir_valid), 64'd1);
      chk("stall_pc", b0.redir_pc, pc0);
      chk("stall_no_priv_we", 64'(b0.priv_we), 64'd0);
    end
    b0.redir_ready = 1'b1;
    @(posedge clk); #1;
    b0.redir_ready = 1'b0;
    chk("hs_valid_down", 64'(b0.redir_valid), 64'd0);
    chk("hs_ret_ready", 64'(b0.ret_ready), 64'd1);
    chk("hs_priv_we", 64'(b0.priv_we), 64'd1);
  endtask

  // Illegal return held for n cycles.
  task automatic run_ill(input logic m, input logic [1:0] p, input logic t, input int n);
    b0.ret_is_mret = m;
    b0.priv        = p;
    b0.tsr         = t;
    b0.ret_valid   = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      chk("illegal_pulse", 64'(b0.illegal), 64'd1);
      chk("illegal_no_flush", 64'(b0.flush_req), 64'd0);
      chk("illegal_ready", 64'(b0.ret_ready), 64'd1);
    end
    b0.ret_valid = 1'b0;
    @(posedge clk); #1;
    chk("illegal_drop", 64'(b0.illegal), 64'd0);
  endtask

  // Asynchronous reset while in FLUSH (stage 0) or REDIR (stage 1).
  task automatic reset_in(input int stage);
    b0.mepc        = 64'h0000_5550;
    b0.mpp         = 2'd3;
    b0.ret_is_mret = 1'b1;
    b0.priv        = 2'd3;
    b0.ret_valid   = 1'b1;
    @(posedge clk); #1;
    b0.ret_valid = 1'b0;
    chk("pre_rst_flush", 64'(b0.flush_req), 64'd1);
    if (stage == 1) begin
      b0.flush_ack = 1'b1;
      @(posedge clk); #1;
      b0.flush_ack = 1'b0;
      chk("pre_rst_redir", 64'(b0.redir_valid), 64'd1);
      b0.redir_ready = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_ret_ready", 64'(b0.ret_ready), 64'd1);
    chk("rst_flush_req", 64'(b0.flush_req), 64'd0);
    chk("rst_redir_valid", 64'(b0.redir_valid), 64'd0);
    chk("rst_redir_pc", b0.redir_pc, 64'd0);
    chk("rst_new_priv", 64'(b0.new_priv), 64'd0);
    chk("rst_priv_we", 64'(b0.priv_we), 64'd0);
    chk("rst16_redir_valid", 64'(b1.redir_valid), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n          = 1'b1;
    b0.redir_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(b0.ret_ready), 64'd1);
    chk("post_rst_flush", 64'(b0.flush_req), 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    b0.ret_valid   = 1'b0;
    b0.ret_is_mret = 1'b0;
    b0.priv        = 2'd0;
    b0.tsr         = 1'b0;
    b0.mepc        = 64'd0;
    b0.sepc        = 64'd0;
    b0.mpp         = 2'd0;
    b0.spp         = 1'b0;
    b0.flush_ack   = 1'b0;
    b0.redir_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ret_ready", 64'(b0.ret_ready), 64'd1);
    chk("reset_illegal", 64'(b0.illegal), 64'd0);
    chk("reset_flush_req", 64'(b0.flush_req), 64'd0);
    chk("reset_redir_valid", 64'(b0.redir_valid), 64'd0);
    chk("reset_priv_we", 64'(b0.priv_we), 64'd0);
    chk("reset16_ret_ready", 64'(b1.ret_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MRET from M, mepc 0x8000_0006, mpp=S, ack two cycles after accept.
    b0.mepc = 64'h8000_0006;
    b0.mpp  = 2'd1;
    push_ok(64'h8000_0004, 64'h8000_0006, 2'd1, 1'b1);
    run_ret(1'b1, 2'd3, 1'b0, 1, 0, 1'b0, 1'b0, 64'h8000_0004);

    // SRET from S with TSR set: trapped.
    push_ill(1);
    run_ill(1'b0, 2'd1, 1'b1, 1);

    // SRET from S without TSR, sepc 0x1000, spp=U.
    b0.sepc = 64'h0000_1000;
    b0.spp  = 1'b0;
    push_ok(64'h0000_1000, 64'h0000_1000, 2'd0, 1'b0);
    run_ret(1'b0, 2'd1, 1'b0, 0, 0, 1'b0, 1'b0, 64'h0000_1000);

    // CSR inputs scribbled during FLUSH must not reach the redirect.
    b0.mepc = 64'h4000_0010;
    b0.mpp  = 2'd3;
    push_ok(64'h4000_0010, 64'h4000_0010, 2'd3, 1'b1);
    run_ret(1'b1, 2'd3, 1'b0, 3, 0, 1'b0, 1'b1, 64'h4000_0010);

    // SRET from M, early ack ignored, fetch stalls 5 cycles.
    b0.sepc = 64'h2468_ACE2;
    b0.spp  = 1'b1;
    push_ok(64'h2468_ACE0, 64'h2468_ACE2, 2'd1, 1'b0);
    run_ret(1'b0, 2'd3, 1'b0, 1, 5, 1'b1, 1'b0, 64'h2468_ACE0);

    // Back-to-back MRET with reserved MPP and odd mepc.
    b0.mepc = 64'h0000_2003;
    b0.mpp  = 2'd2;
    push_ok(64'h0000_2000, 64'h0000_2002, 2'd0, 1'b1);
    run_ret(1'b1, 2'd3, 1'b0, 0, 0, 1'b0, 1'b0, 64'h0000_2000);

    // MRET from S held three cycles, SRET from U, MRET from U.
    push_ill(3);
    run_ill(1'b1, 2'd1, 1'b0, 3);
    push_ill(1);
    run_ill(1'b0, 2'd0, 1'b0, 1);
    push_ill(1);
    run_ill(1'b1, 2'd0, 1'b0, 1);

    // Resets mid-flight drop the return silently.
    reset_in(0);
    reset_in(1);

    // Normal operation resumes after reset.
    b0.sepc = 64'h0000_3006;
    b0.spp  = 1'b1;
    push_ok(64'h0000_3004, 64'h0000_3006, 2'd1, 1'b0);
    run_ret(1'b0, 2'd1, 1'b0, 2, 1, 1'b0, 1'b0, 64'h0000_3004);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty_dut0", 64'(q0.size()), 64'd0);
    chk("scoreboard_empty_dut1", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xret_pc_unit.md
# xret_pc_unit

Trap-return redirect unit. Consumes MRET/SRET from the execute stage, checks privilege legality, requests a pipeline flush, then drives the fetch redirect to the saved exception PC from the CSR block (mepc/sepc). After the redirect handshake it commands the privilege update and the mstatus stack pop (xIE←xPIE) for the CSR block.

## Interface
Parameters:
- XLEN, 64, PC/CSR width
- IALIGN16, 0: 1 clears only bit 0 of the target PC; 0 clears bits [1:0]

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ret_valid  in  1  xRET instruction presented
- ret_is_mret  in  1  1 = MRET, 0 = SRET; qualified by ret_valid
- ret_ready  out  1  unit accepts xRET (high only in IDLE)
- priv  in  2  current privilege (0 U, 1 S, 3 M)
- tsr  in  1  mstatus.TSR
- mepc, sepc  in  XLEN  live xEPC values
- mpp  in  2  mstatus.MPP
- spp  in  1  mstatus.SPP
- illegal  out  1  one-cycle pulse: rejected xRET
- flush_req  out  1  pipeline flush request
- flush_ack  in  1  pipeline drained
- redir_valid  out  1  redirect PC valid
- redir_pc  out  XLEN  redirect target
- redir_ready  in  1  fetch takes redirect
- priv_we  out  1  one-cycle pulse: load new_priv
- new_priv  out  2  privilege to enter
- done_m, done_s  out  1  one-cycle pulse: pop M/S status stack

## Operation
- FSM states: IDLE, FLUSH, REDIR.
- IDLE: ret_ready=1. On ret_valid, a combinational check runs:
  - MRET is illegal unless priv==3.
  - SRET is illegal if priv==0, or if priv==1 and tsr==1.
- Illegal: illegal pulses the next cycle and the FSM stays in IDLE. Nothing else changes.
- Legal: on the acceptance edge the unit latches the following, then goes to FLUSH:
  - target PC = mepc (MRET) or sepc (SRET), with the alignment mask applied.
  - target priv:
    - MRET: mpp, with reserved value 2 mapped to 0.
    - SRET: {0, spp}.
  - kind bit (M or S).
- Latched values are frozen. Any later change on mepc/sepc/mpp/spp does not alter the in-flight return.
- FLUSH: flush_req=1 until flush_ack is sampled high, then go to REDIR. flush_ack is ignored in every other state.
- REDIR: redir_valid=1, redir_pc = latched PC. When redir_valid && redir_ready:
  - next cycle: priv_we pulses, new_priv = latched priv, and done_m or done_s pulses according to kind.
  - FSM returns to IDLE.
- All outputs are registered. redir_pc, new_priv and kind hold their last value when not valid.
- Reset (asynchronous, any state): FSM goes to IDLE, all registers clear, and every output is 0 except ret_ready=1. An in-flight xRET is dropped, with no priv_we or done pulse.

## Timing
- Acceptance at edge N → flush_req high from cycle N+1.
- flush_ack high in cycle N+k (k≥1) → redir_valid high from cycle N+k+1.
- redir_ready high in cycle R while redir_valid → redir_valid low and priv_we/done pulse in R+1, ret_ready high in R+1.
- Minimum accept-to-accept spacing: 3 cycles. Back-to-back xRET is accepted at R+1 at the earliest.
- Illegal pulse is exactly one cycle, at N+1. A held illegal ret_valid re-pulses every cycle.
- flush_ack arriving in the acceptance cycle is not counted.

## Structure
- Shared package (csr_pkg): privilege encodings PRIV_U=0, PRIV_S=1, PRIV_M=3, PRIV_RSVD=2; FSM state enum; XLEN default.
- Sub-module xret_legal_chk: combinational legality check. Inputs: ret_is_mret, priv, tsr. Output: legal.
- Top module: FSM, latches, alignment mask, output registers.

## Test plan
- priv=3, MRET, mepc=0x8000_0006, mpp=1, flush_ack 2 cycles later, redir_ready immediately → redir_pc=0x8000_0004, then priv_we with new_priv=1 and done_m=1 for one cycle.
- priv=1, tsr=1, SRET → illegal pulse for 1 cycle, no flush_req, FSM stays in IDLE. Repeat with tsr=0, sepc=0x1000, spp=0 → redir_pc=0x1000, new_priv=0, done_s.
- MRET accepted, then mepc changed to 0xDEAD_0000 during FLUSH → redir_pc still equals the latched value.
- redir_ready held low for 5 cycles → redir_valid and redir_pc stable throughout, no priv_we until the handshake.
- rst_n asserted in FLUSH and again in REDIR → outputs clear immediately, no priv_we/done pulse, ret_ready=1 after release.
- MRET with mpp=2 and IALIGN16=1, mepc=0x2003 → redir_pc=0x2002, new_priv=0.
